// File: rtl/reset_ctrl.sv
// reset_ctrl: multi-source reset controller with per-source sync/debounce, stretch FSM and sticky cause register
module reset_ctrl #(
   parameter int                 N_SRC           = 2,
   parameter logic [N_SRC-1:0]   SRC_POL         = 2'b01,
   parameter logic [N_SRC-1:0]   SRC_STRETCH     = 2'b01,
   parameter int                 SYNC_STAGES     = 2,
   parameter int                 DEBOUNCE_CYCLES = 16000,
   parameter int                 PULSE_CYCLES    = 8000000
) (
   input  logic             clock,
   input  logic             async_res,
   input  logic [N_SRC-1:0] src_in,
   input  logic             cause_clr,
   output logic             res,
   output logic [N_SRC-1:0] cause,
   output logic             busy
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = $clog2(PULSE_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, HOLD, PULSE} state_t;

   logic [N_SRC-1:0] sync_q [SYNC_STAGES];
   logic [N_SRC-1:0] lvl, req;
   logic             any_req, pt_req;
   state_t           state_q;
   logic [PW-1:0]    pcnt_q;
   logic             res_q, busy_q;
   logic [N_SRC-1:0] cause_q, cause_d;

   // synchroniser chains, idling at each source's inactive level
   always_ff @(posedge clock or posedge async_res) begin
      if (async_res) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= ~SRC_POL;
      end else begin
         sync_q[0] <= src_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end

   assign lvl = ~(sync_q[SYNC_STAGES-1] ^ SRC_POL);

   for (genvar i = 0; i < N_SRC; i++) begin : g_src
      if (SRC_STRETCH[i]) begin : g_deb
         logic [DW-1:0] cnt_q, cnt_d;
         logic          req_q;
         assign cnt_d = !lvl[i] ? '0 : (cnt_q == DW'(DEBOUNCE_CYCLES)) ? cnt_q : cnt_q + 1'b1;
         // saturating debounce counter; request registered once it reaches the threshold
         always_ff @(posedge clock or posedge async_res) begin
            if (async_res) begin
               cnt_q <= '0;
               req_q <= 1'b0;
            end else begin
               cnt_q <= cnt_d;
               req_q <= (cnt_d == DW'(DEBOUNCE_CYCLES));
            end
         end
         assign req[i] = req_q;
      end else begin : g_pt
         assign req[i] = lvl[i];
      end
   end

   assign any_req = |(req & SRC_STRETCH);
   assign pt_req  = |(req & ~SRC_STRETCH);

   // stretch FSM; res follows the next FSM state ORed with pass-through requests
   always_ff @(posedge clock or posedge async_res) begin
      if (async_res) begin
         state_q <= PULSE;
         pcnt_q  <= '0;
         res_q   <= 1'b1;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= any_req ? HOLD : IDLE;
               res_q   <= any_req | pt_req;
               busy_q  <= any_req;
            end
            HOLD: begin
               if (!any_req) begin
                  state_q <= PULSE;
                  pcnt_q  <= '0;
               end
               res_q  <= 1'b1;
               busy_q <= 1'b1;
            end
            PULSE: begin
               if (any_req) begin
                  state_q <= HOLD;
                  pcnt_q  <= '0;
                  res_q   <= 1'b1;
                  busy_q  <= 1'b1;
               end else if (pcnt_q == PW'(PULSE_CYCLES - 1)) begin
                  state_q <= IDLE;
                  res_q   <= pt_req;
                  busy_q  <= 1'b0;
               end else begin
                  pcnt_q <= pcnt_q + 1'b1;
                  res_q  <= 1'b1;
                  busy_q <= 1'b1;
               end
            end
            default: begin
               state_q <= PULSE;
               pcnt_q  <= '0;
               res_q   <= 1'b1;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign cause_d = (cause_q & ~{N_SRC{cause_clr}}) | req;

   // sticky cause bits; a new request beats a simultaneous clear
   always_ff @(posedge clock or posedge async_res) begin
      if (async_res) cause_q <= '0;
      else cause_q <= cause_d;
   end

   assign res   = res_q;
   assign busy  = busy_q;
   assign cause = cause_q;
endmodule
